// File: rtl/branch_predict_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module : branch_predict_control_pkg
//  Brief  : Branch condition encodings, 2-bit counter states, condition decode.
//  Rev    : 1.0
// ============================================================================
package branch_predict_control_pkg;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    localparam logic [1:0] c_CNT_SNT = 2'b00;
    localparam logic [1:0] c_CNT_WNT = 2'b01;
    localparam logic [1:0] c_CNT_WT  = 2'b10;
    localparam logic [1:0] c_CNT_ST  = 2'b11;

    typedef struct packed {
        logic legal;
        logic taken;
    } br_cond_t;

    // Encodings 010/011 have no branch meaning: reported illegal and not taken.
    function automatic br_cond_t decode_cond(input logic [2:0] f3, input logic zero,
                                             input logic less, input logic lessu);
        br_cond_t r;
        r.legal = 1'b1;
        r.taken = 1'b0;
        case (f3)
            c_F3_BEQ:  r.taken = zero;
            c_F3_BNE:  r.taken = ~zero;
            c_F3_BLT:  r.taken = less;
            c_F3_BGE:  r.taken = ~less;
            c_F3_BLTU: r.taken = lessu;
            c_F3_BGEU: r.taken = ~lessu;
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
//  Module : branch_history_table
//  Brief  : 2**IDX_W two-bit saturating counters, one read and one RMW port.
//  Rev    : 1.0
// ============================================================================
module branch_history_table
    import branch_predict_control_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_cnt,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [1:0] r_cnt [c_DEPTH];
    logic [1:0] w_cur;
    logic [1:0] w_nxt;

    assign o_rd_cnt = r_cnt[i_rd_idx];
    assign w_cur    = r_cnt[i_wr_idx];

    always_comb begin
        w_nxt = w_cur;
        if (i_wr_taken && (w_cur != c_CNT_ST))
            w_nxt = w_cur + 2'd1;
        else if (!i_wr_taken && (w_cur != c_CNT_SNT))
            w_nxt = w_cur - 2'd1;
    end

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_cnt[gi] <= c_CNT_WNT;
            else if (i_wr_en && (i_wr_idx == IDX_W'(gi)))
                r_cnt[gi] <= w_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_control.sv
`default_nettype none
// ============================================================================
//  Module : branch_predict_control
//  Brief  : Bimodal predictor with branch resolve, mispredict pulse and stats.
//  Rev    : 1.0
// ============================================================================
module branch_predict_control
    import branch_predict_control_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [2:0]        Funct3,
    input  logic              Branch,
    input  logic              ForceJump,
    input  logic              Zero,
    input  logic              Less,
    input  logic              LessU,
    input  logic              res_pred_taken,
    output logic              BranchMux,
    output logic              mispredict,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] miss_count
);

    br_cond_t          w_cond;
    logic              w_update;
    logic              w_ctl;
    logic              w_miss;
    logic [1:0]        w_rd_cnt;
    logic              r_mispredict;
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_miss_count;

    assign w_cond    = decode_cond(Funct3, Zero, Less, LessU);
    assign BranchMux = res_valid & (ForceJump | (Branch & w_cond.taken));
    assign w_update  = res_valid & Branch & ~ForceJump & w_cond.legal;
    assign w_ctl     = res_valid & (Branch | ForceJump);
    assign w_miss    = w_ctl & (BranchMux != res_pred_taken);

    // Table read is not bypassed: a same-cycle update is seen one cycle later.
    branch_history_table #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (pred_pc[IDX_W+1:2]),
        .o_rd_cnt  (w_rd_cnt),
        .i_wr_en   (w_update),
        .i_wr_idx  (res_pc[IDX_W+1:2]),
        .i_wr_taken(w_cond.taken)
    );

    assign pred_taken = w_rd_cnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mispredict <= 1'b0;
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            r_mispredict <= w_miss;
            if (stat_clear) begin
                r_br_count   <= '0;
                r_miss_count <= '0;
            end else begin
                if (w_ctl && (r_br_count != '1))
                    r_br_count <= r_br_count + 1'b1;
                if (w_miss && (r_miss_count != '1))
                    r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    assign mispredict = r_mispredict;
    assign br_count   = r_br_count;
    assign miss_count = r_miss_count;

    logic w_unused_bits;
    assign w_unused_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                             res_pc[PC_W-1:IDX_W+2], res_pc[1:0], w_rd_cnt[0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_control.sv
`default_nettype none
// ============================================================================
//  Module : tb_branch_predict_control
//  Brief  : Scoreboard bench for branch_predict_control.
//  Rev    : 1.0
// ============================================================================
module tb_branch_predict_control;

    localparam int IDX_W  = 6;
    localparam int PC_W   = 32;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PC_W-1:0]   pred_pc = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic [PC_W-1:0]   res_pc = '0;
    logic [2:0]        Funct3 = 3'b000;
    logic              Branch = 1'b0;
    logic              ForceJump = 1'b0;
    logic              Zero = 1'b0;
    logic              Less = 1'b0;
    logic              LessU = 1'b0;
    logic              res_pred_taken = 1'b0;
    logic              BranchMux;
    logic              mispredict;
    logic              stat_clear = 1'b0;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] miss_count;

    branch_predict_control #(
        .IDX_W(IDX_W), .PC_W(PC_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .Funct3(Funct3), .Branch(Branch),
        .ForceJump(ForceJump), .Zero(Zero), .Less(Less), .LessU(LessU),
        .res_pred_taken(res_pred_taken), .BranchMux(BranchMux), .mispredict(mispredict),
        .stat_clear(stat_clear), .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              mux;
        logic              pred;
        logic              misp;
        logic [STAT_W-1:0] br;
        logic [STAT_W-1:0] miss;
    } res_t;

    res_t              exp_q[$];
    res_t              obs;
    res_t              e;
    logic [1:0]        m_bht [1 << IDX_W];
    logic [STAT_W-1:0] m_br;
    logic [STAT_W-1:0] m_miss;
    int                checks = 0;
    int                passed = 0;

    task automatic reset_model();
        for (int i = 0; i < (1 << IDX_W); i++) m_bht[i] = 2'b01;
        m_br   = '0;
        m_miss = '0;
        exp_q.delete();
    endtask

    // Drives one cycle of resolve stimulus (entered at posedge+1), predicts the
    // outcome from the bench model, queues it, and captures what the DUT shows.
    task automatic apply(input logic v, input logic [PC_W-1:0] pc, input logic [2:0] f3,
                         input logic br, input logic fj, input logic z, input logic l,
                         input logic lu, input logic pt, input logic clr);
        res_t ex;
        logic cond, legal, ctl;
        logic [IDX_W-1:0] idx;
        res_valid = v; res_pc = pc; Funct3 = f3; Branch = br; ForceJump = fj;
        Zero = z; Less = l; LessU = lu; res_pred_taken = pt; stat_clear = clr;
        #2;
        obs.mux  = BranchMux;
        obs.pred = pred_taken;
        legal = 1'b1;
        case (f3)
            3'b000:  cond = z;
            3'b001:  cond = !z;
            3'b100:  cond = l;
            3'b101:  cond = !l;
            3'b110:  cond = lu;
            3'b111:  cond = !lu;
            default: begin cond = 1'b0; legal = 1'b0; end
        endcase
        ex.mux  = v & (fj | (br & cond));
        ex.pred = m_bht[pred_pc[IDX_W+1:2]][1];
        ctl     = v & (br | fj);
        ex.misp = ctl & (ex.mux != pt);
        if (v && br && !fj && legal) begin
            idx = pc[IDX_W+1:2];
            if (cond && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
            else if (!cond && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
        end
        if (clr) begin
            m_br = '0; m_miss = '0;
        end else begin
            if (ctl && m_br != '1) m_br = m_br + 1'b1;
            if (ex.misp && m_miss != '1) m_miss = m_miss + 1'b1;
        end
        ex.br = m_br; ex.miss = m_miss;
        exp_q.push_back(ex);
        @(posedge clk); #1;
        obs.misp = mispredict; obs.br = br_count; obs.miss = miss_count;
        res_valid = 1'b0; stat_clear = 1'b0; Branch = 1'b0; ForceJump = 1'b0;
    endtask

    task automatic test_reset();
        reset_model();
        pred_pc = 32'h40;
        #1;
        checks++;
        if ({pred_taken, mispredict, br_count, miss_count} !== {1'b0, 1'b0, 4'd0, 4'd0})
            $display("FAIL reset_state: got pt=%b misp=%b br=%0d miss=%0d want 0 0 0 0",
                     pred_taken, mispredict, br_count, miss_count);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_beq_taken();
        pred_pc = 32'h40;
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h40, 3'b000, 1, 0, 1, 0, 0, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e || obs.mux !== 1'b1 || obs.misp !== 1'b1)
                $display("FAIL beq_taken[%0d]: got %h want %h", i, obs, e);
            else passed++;
        end
        apply(0, 32'h0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e || obs.misp !== 1'b0)
            $display("FAIL beq_pulse_end: got %h want %h", obs, e);
        else passed++;
        pred_pc = 32'h40; #1;
        checks++;
        if (pred_taken !== 1'b1) $display("FAIL beq_pred_40: got %b want 1", pred_taken);
        else passed++;
        pred_pc = 32'h140; #1;
        checks++;
        if (pred_taken !== 1'b1) $display("FAIL beq_pred_alias: got %b want 1", pred_taken);
        else passed++;
        checks++;
        if (br_count !== 4'd2 || miss_count !== 4'd2)
            $display("FAIL beq_counts: got br=%0d miss=%0d want br=2 miss=2", br_count, miss_count);
        else passed++;
    endtask

    task automatic test_bne_saturate();
        pred_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            apply(1, 32'h80, 3'b001, 1, 0, 1, 0, 0, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e || obs.mux !== 1'b0)
                $display("FAIL bne_not_taken[%0d]: got %h want %h", i, obs, e);
            else passed++;
        end
        // One taken step from a floor of 00 must still predict not-taken.
        apply(1, 32'h80, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e) $display("FAIL bne_floor_step: got %h want %h", obs, e);
        else passed++;
        #1; checks++;
        if (pred_taken !== 1'b0) $display("FAIL bne_floor_pred: got %b want 0", pred_taken);
        else passed++;
    endtask

    task automatic test_force_jump();
        pred_pc = 32'h40;
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h40, 3'b111, 1, 1, 0, 0, 1, 0, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e || obs.mux !== 1'b1 || obs.misp !== 1'b1)
                $display("FAIL force_jump[%0d]: got %h want %h", i, obs, e);
            else passed++;
        end
        #1; checks++;
        if (pred_taken !== 1'b1) $display("FAIL force_jump_table: got %b want 1", pred_taken);
        else passed++;
    endtask

    task automatic test_illegal_and_clear();
        pred_pc = 32'h40;
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h40, 3'b010, 1, 0, 1, 1, 1, 1, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e || obs.mux !== 1'b0 || obs.misp !== 1'b1)
                $display("FAIL illegal_f3[%0d]: got %h want %h", i, obs, e);
            else passed++;
        end
        #1; checks++;
        if (pred_taken !== 1'b1) $display("FAIL illegal_table: got %b want 1", pred_taken);
        else passed++;
        apply(1, 32'h80, 3'b000, 1, 0, 1, 0, 0, 0, 1);
        e = exp_q.pop_front(); checks++;
        if (obs !== e || obs.br !== 4'd0 || obs.miss !== 4'd0)
            $display("FAIL stat_clear: got %h want %h", obs, e);
        else passed++;
    endtask

    task automatic test_cond_codes();
        logic [2:0] codes [6];
        codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                pred_pc = 32'h100 + 32'(i * 4);
                apply(1, 32'h100 + 32'(i * 4), codes[i], 1, 0, 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 0);
                e = exp_q.pop_front(); checks++;
                if (obs !== e) $display("FAIL cond_f3_%b[%0d]: got %h want %h", codes[i], r, obs, e);
                else passed++;
            end
        end
    endtask

    task automatic test_same_cycle();
        pred_pc = 32'h3C;
        for (int i = 0; i < 2; i++) begin
            apply(1, 32'h3C, 3'b000, 1, 0, 1, 0, 0, 1, 0);
            e = exp_q.pop_front(); checks++;
            if (obs !== e || obs.pred !== 1'(i))
                $display("FAIL same_cycle[%0d]: got %h want %h", i, obs, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        pred_pc = 32'h200;
        for (int i = 0; i < 20; i++)
            apply(1, 32'h200, 3'b100, 1, 0, 0, 1'(i % 3 == 0), 0, 1'(i % 2), 0);
        for (int i = 0; i < 20; i++) begin
            e = exp_q.pop_front();
            if (i == 19) begin
                checks++;
                if (obs !== e || obs.br !== 4'hF)
                    $display("FAIL back_to_back_sat: got %h want %h", obs, e);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic bad;
        apply(1, 32'h3C, 3'b000, 1, 0, 1, 0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs !== e || obs.misp !== 1'b1) $display("FAIL areset_pre: got %h want %h", obs, e);
        else passed++;
        #1 rst = 1'b1;
        #1; checks++;
        if ({mispredict, br_count, miss_count} !== 9'd0)
            $display("FAIL areset_immediate: got misp=%b br=%0d miss=%0d want 0 0 0",
                     mispredict, br_count, miss_count);
        else passed++;
        reset_model();
        bad = 1'b0;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            pred_pc = 32'(i * 4); #1;
            if (pred_taken !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL areset_table: got some entry predicting taken want all 01");
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        res_valid = 1'b1; res_pc = 32'h40; Funct3 = 3'b000; Branch = 1'b1; Zero = 1'b1;
        res_pred_taken = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0; Branch = 1'b0;
        pred_pc = 32'h40; #1; checks++;
        if (pred_taken !== 1'b0 || mispredict !== 1'b0)
            $display("FAIL areset_pending: got pt=%b misp=%b want 0 0", pred_taken, mispredict);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_saturate();
        test_force_jump();
        test_illegal_and_clear();
        test_cond_codes();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
